// File: rtl/vmem_pkg.sv
// Shared types and sizing helpers for the vector memory responder and its lane sequencer.
package vmem_pkg;

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} vmem_state_t;

  typedef enum logic {OP_LD, OP_ST} vmem_op_t;

  localparam int unsigned VMEM_R     = 6;
  localparam int unsigned LANE_CNT_W = $clog2(VMEM_R + 1);

  // Counter must reach R (not just R-1) so the read path can flag its trailing capture cycle.
  function automatic int unsigned laneCntW(input int unsigned r);
    return $clog2(r + 1);
  endfunction

endpackage

// File: rtl/vmem_lane_seq.sv
// Lane counter k with clear/increment and flags for the last write lane (R-1) and last read
// capture (R).
module vmem_lane_seq #(
  parameter int unsigned R  = 6,
  parameter int unsigned KW = $clog2(R + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          inc,
  output logic [KW-1:0] k,
  output logic          last,
  output logic          lastRd
);

  logic [KW-1:0] kQ, kD;

  always_comb begin
    kD = kQ;
    if (clear) begin
      kD = '0;
    end else if (inc) begin
      kD = kQ + KW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      kQ <= '0;
    end else begin
      kQ <= kD;
    end
  end

  assign k      = kQ;
  assign last   = (kQ == KW'(R - 1));
  assign lastRd = (kQ == KW'(R));

endmodule

// File: rtl/vector_mem_responder.sv
// Serializes one R-lane vector load/store into byte accesses on a single-port synchronous RAM,
// stalling the pipeline until the DONE cycle.
module vector_mem_responder
  import vmem_pkg::*;
#(
  parameter int unsigned I  = 32,
  parameter int unsigned N  = 8,
  parameter int unsigned R  = 6,
  parameter int unsigned AW = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                MemWriteM,
  input  logic                MemReadM,
  input  logic [I-1:0]        AddressM,
  input  logic [R-1:0][N-1:0] WriteDataM,
  output logic [R-1:0][N-1:0] ReadData,
  output logic                StallM,
  output logic [AW-1:0]       ram_addr,
  output logic                ram_we,
  output logic [N-1:0]        ram_wdata,
  input  logic [N-1:0]        ram_rdata
);

  localparam int unsigned KW = laneCntW(R);

  vmem_state_t         stateQ, stateD;
  logic [AW-1:0]       baseQ;
  logic [R-1:0][N-1:0] wdataQ;
  logic [R-1:0][N-1:0] readDataQ;
  logic [AW-1:0]       lastAddrQ;

  logic          req;
  logic          accept;
  vmem_op_t      reqOp;
  logic [KW-1:0] k;
  logic [KW-1:0] laneIdx;
  logic          last;
  logic          lastRd;
  logic          capture;
  logic [AW-1:0] laneAddr;
  logic          unusedAddrHi;

  assign req          = MemWriteM | MemReadM;
  assign accept       = (stateQ == IDLE) && req;
  // A simultaneous read is dropped: store takes priority.
  assign reqOp        = MemWriteM ? OP_ST : OP_LD;
  assign laneAddr     = baseQ + AW'(k);
  assign laneIdx      = k - KW'(1);
  assign unusedAddrHi = ^AddressM[I-1:AW];

  vmem_lane_seq #(
    .R  (R),
    .KW (KW)
  ) u_lane_seq (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept),
    .inc    ((stateQ == WRITE) || (stateQ == READ)),
    .k      (k),
    .last   (last),
    .lastRd (lastRd)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateQ    <= IDLE;
      baseQ     <= '0;
      wdataQ    <= '0;
      readDataQ <= '0;
      lastAddrQ <= '0;
    end else begin
      stateQ    <= stateD;
      lastAddrQ <= ram_addr;
      if (accept) begin
        baseQ  <= AddressM[AW-1:0];
        wdataQ <= WriteDataM;
      end
      if (capture) begin
        readDataQ[laneIdx] <= ram_rdata;
      end
    end
  end

  // A request still high in DONE belongs to the instruction just served, so it is ignored.
  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      IDLE:    if (req) stateD = (reqOp == OP_ST) ? WRITE : READ;
      WRITE:   if (last) stateD = DONE;
      READ:    if (lastRd) stateD = DONE;
      DONE:    stateD = IDLE;
      default: stateD = IDLE;
    endcase
  end

  always_comb begin
    StallM    = 1'b0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    ram_addr  = lastAddrQ;
    capture   = 1'b0;
    unique case (stateQ)
      IDLE:  StallM = req;
      WRITE: begin
        StallM    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = laneAddr;
        ram_wdata = wdataQ[k];
      end
      READ: begin
        StallM = 1'b1;
        if (!lastRd) ram_addr = laneAddr;
        // RAM data lags the address by one cycle, so lane k-1 lands while k is issued.
        capture = (k != '0);
      end
      DONE:    StallM = 1'b0;
      default: StallM = 1'b0;
    endcase
  end

  assign ReadData = readDataQ;

endmodule
